// File: rtl/controle_multiciclo.sv
// ---------------------------------------------------------------------------
// controle_multiciclo
// Main control FSM for a multicycle MIPS-like datapath. Sequences instruction
// fetch (with a configurable memory latency), decode, execute, memory access,
// write-back, branch, jump and exception handling, and drives every datapath
// write enable and mux select. Outputs are decoded from the current state;
// opcode/funct/flags are read from the (stable) IR and ALU status.
//
// Parameters
//   MEM_WAIT  memory read latency in cycles (1..7)
//   OVF_TRAP  1 = ADD/SUB/ADDI overflow raises an exception
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   opcode, funct               IR[31:26], IR[5:0]
//   flags                       ALU status: 0 ovf, 1 neg, 2 zero, 3 lt, 4 gt
//   pc_write .. epc_write       register write enables
//   pc_source, addr_source,
//   alu_src_a, alu_src_b,
//   reg_dst, mem_to_reg         datapath mux selects
//   alu_op                      0 ADD, 1 SUB, 2 AND
//   reset_out                   reset to datapath modules
//   state_dbg                   current state encoding
// ---------------------------------------------------------------------------
module controle_multiciclo #(
   parameter int MEM_WAIT = 2,
   parameter int OVF_TRAP = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic [5:0] flags,
   output logic       pc_write,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       ab_write,
   output logic       aluout_write,
   output logic       epc_write,
   output logic [1:0] pc_source,
   output logic [1:0] addr_source,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] reg_dst,
   output logic       mem_to_reg,
   output logic [2:0] alu_op,
   output logic       reset_out,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_WB_ALU   = 4'd8,
      S_WB_MEM   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_EXC      = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_SWRST = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;

   // Counter value on the last cycle of FETCH and of MEM_RD respectively.
   localparam logic [2:0] FETCH_LAST = 3'(MEM_WAIT);
   localparam logic [2:0] MEMRD_LAST = 3'(MEM_WAIT - 1);

   state_t     state, state_next;
   logic [2:0] cnt, cnt_next;
   logic       ovf_trap;

   // Only overflow and zero steer the controller; the other flags are unused.
   logic unused_flags;
   assign unused_flags = ^{flags[5:3], flags[1]};

   // The overflow decision is taken while the ALU result is still on the bus
   // (EXEC_R / EXEC_I), so a trapping op never reaches the write-back cycle.
   assign ovf_trap  = (OVF_TRAP != 0) && flags[0];
   assign state_dbg = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_RESET;
         cnt   <= 3'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next   = state;
      pc_write     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      ab_write     = 1'b0;
      aluout_write = 1'b0;
      epc_write    = 1'b0;
      pc_source    = 2'd0;
      addr_source  = 2'd0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      reg_dst      = 2'd0;
      mem_to_reg   = 1'b0;
      alu_op       = ALU_ADD;
      reset_out    = 1'b0;

      case (state)
         S_RESET: begin
            reset_out  = 1'b1;
            state_next = S_FETCH;
         end
         S_FETCH: begin
            // Memory read of the instruction; PC+4 written together with IR.
            if (cnt == FETCH_LAST) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               alu_src_b  = 2'd1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // Register read plus speculative branch target PC + (imm<<2).
            ab_write     = 1'b1;
            aluout_write = 1'b1;
            alu_src_b    = 2'd3;
            case (opcode)
               OP_RTYPE:      state_next = S_EXEC_R;
               OP_ADDI:       state_next = S_EXEC_I;
               OP_LW, OP_SW:  state_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_next = S_BRANCH;
               OP_J:          state_next = S_JUMP;
               OP_SWRST:      state_next = S_RESET;
               default:       state_next = S_EXC;
            endcase
         end
         S_EXEC_R: begin
            alu_src_a    = 1'b1;
            aluout_write = 1'b1;
            case (funct)
               FN_ADD: begin
                  alu_op     = ALU_ADD;
                  state_next = ovf_trap ? S_EXC : S_WB_ALU;
               end
               FN_SUB: begin
                  alu_op     = ALU_SUB;
                  state_next = ovf_trap ? S_EXC : S_WB_ALU;
               end
               FN_AND: begin
                  alu_op     = ALU_AND;
                  state_next = S_WB_ALU;
               end
               default: state_next = S_EXC;
            endcase
         end
         S_EXEC_I: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 2'd2;
            aluout_write = 1'b1;
            state_next   = ovf_trap ? S_EXC : S_WB_ALU;
         end
         S_MEM_ADDR: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 2'd2;
            aluout_write = 1'b1;
            state_next   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            addr_source = 2'd1;
            if (cnt == MEMRD_LAST) state_next = S_WB_MEM;
         end
         S_MEM_WR: begin
            addr_source = 2'd1;
            mem_write   = 1'b1;
            state_next  = S_FETCH;
         end
         S_WB_ALU: begin
            reg_write  = 1'b1;
            reg_dst    = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
            state_next = S_FETCH;
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            if (((opcode == OP_BEQ) && flags[2]) || ((opcode == OP_BNE) && !flags[2])) begin
               pc_write  = 1'b1;
               pc_source = 2'd1;
            end
            state_next = S_FETCH;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = 2'd2;
            state_next = S_FETCH;
         end
         S_EXC: begin
            epc_write  = 1'b1;
            pc_write   = 1'b1;
            pc_source  = 2'd3;
            state_next = S_FETCH;
         end
         default: state_next = S_RESET;
      endcase

      // Counter restarts on each state change and saturates inside a state.
      if (state_next != state) cnt_next = 3'd0;
      else if (cnt != 3'd7)    cnt_next = cnt + 3'd1;
      else                     cnt_next = cnt;
   end

endmodule

// File: tb/tb_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_controle_multiciclo
// Directed bench for controle_multiciclo. Three instances share the stimulus:
// MEM_WAIT=2/OVF_TRAP=1, MEM_WAIT=3/OVF_TRAP=1 and MEM_WAIT=2/OVF_TRAP=0.
// Expected per-cycle output vectors are queued when an instruction is set up
// and compared against the selected instance one cycle at a time.
// Vector: {pc_w,mem_w,ir_w,reg_w,ab_w,aluout_w,epc_w, pc_src, addr_src,
//          src_a, src_b, reg_dst, mem_to_reg, alu_op, reset_out, state}
// ---------------------------------------------------------------------------
module tb_controle_multiciclo;

   logic       clk;
   logic       reset;
   logic [5:0] opcode, funct, flags;

   logic [24:0] o2, o3, ont;

   logic       a_pcw, a_mw, a_irw, a_rw, a_abw, a_aow, a_epcw, a_asa, a_m2r, a_ro;
   logic [1:0] a_pcs, a_adr, a_asb, a_rd;
   logic [2:0] a_aop;
   logic [3:0] a_st;
   logic       b_pcw, b_mw, b_irw, b_rw, b_abw, b_aow, b_epcw, b_asa, b_m2r, b_ro;
   logic [1:0] b_pcs, b_adr, b_asb, b_rd;
   logic [2:0] b_aop;
   logic [3:0] b_st;
   logic       c_pcw, c_mw, c_irw, c_rw, c_abw, c_aow, c_epcw, c_asa, c_m2r, c_ro;
   logic [1:0] c_pcs, c_adr, c_asb, c_rd;
   logic [2:0] c_aop;
   logic [3:0] c_st;

   controle_multiciclo #(.MEM_WAIT(2), .OVF_TRAP(1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .flags(flags),
      .pc_write(a_pcw), .mem_write(a_mw), .ir_write(a_irw), .reg_write(a_rw),
      .ab_write(a_abw), .aluout_write(a_aow), .epc_write(a_epcw),
      .pc_source(a_pcs), .addr_source(a_adr), .alu_src_a(a_asa), .alu_src_b(a_asb),
      .reg_dst(a_rd), .mem_to_reg(a_m2r), .alu_op(a_aop), .reset_out(a_ro),
      .state_dbg(a_st));

   controle_multiciclo #(.MEM_WAIT(3), .OVF_TRAP(1)) dut_w3 (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .flags(flags),
      .pc_write(b_pcw), .mem_write(b_mw), .ir_write(b_irw), .reg_write(b_rw),
      .ab_write(b_abw), .aluout_write(b_aow), .epc_write(b_epcw),
      .pc_source(b_pcs), .addr_source(b_adr), .alu_src_a(b_asa), .alu_src_b(b_asb),
      .reg_dst(b_rd), .mem_to_reg(b_m2r), .alu_op(b_aop), .reset_out(b_ro),
      .state_dbg(b_st));

   controle_multiciclo #(.MEM_WAIT(2), .OVF_TRAP(0)) dut_nt (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .flags(flags),
      .pc_write(c_pcw), .mem_write(c_mw), .ir_write(c_irw), .reg_write(c_rw),
      .ab_write(c_abw), .aluout_write(c_aow), .epc_write(c_epcw),
      .pc_source(c_pcs), .addr_source(c_adr), .alu_src_a(c_asa), .alu_src_b(c_asb),
      .reg_dst(c_rd), .mem_to_reg(c_m2r), .alu_op(c_aop), .reset_out(c_ro),
      .state_dbg(c_st));

   assign o2  = {a_pcw, a_mw, a_irw, a_rw, a_abw, a_aow, a_epcw, a_pcs, a_adr,
                 a_asa, a_asb, a_rd, a_m2r, a_aop, a_ro, a_st};
   assign o3  = {b_pcw, b_mw, b_irw, b_rw, b_abw, b_aow, b_epcw, b_pcs, b_adr,
                 b_asa, b_asb, b_rd, b_m2r, b_aop, b_ro, b_st};
   assign ont = {c_pcw, c_mw, c_irw, c_rw, c_abw, c_aow, c_epcw, c_pcs, c_adr,
                 c_asa, c_asb, c_rd, c_m2r, c_aop, c_ro, c_st};

   int checks = 0;
   int errors = 0;

   logic [24:0] exp_q[$];
   string       tag_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [24:0] ov(input logic [3:0] st, input logic [6:0] en,
                                      input logic [1:0] pcs, input logic [1:0] adr,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] rd, input logic m2r,
                                      input logic [2:0] aop, input logic ro);
      return {en, pcs, adr, asa, asb, rd, m2r, aop, ro, st};
   endfunction

   task automatic check(input int sel, input logic [24:0] exp, input string tag);
      logic [24:0] obs;
      obs = (sel == 1) ? o3 : (sel == 2) ? ont : o2;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [24:0] v, input string tag);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   // Compare one queued vector per clock; entered and left at posedge+1.
   task automatic drain(input int sel);
      logic [24:0] e;
      string       t;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         @(negedge clk);
         check(sel, e, t);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_fetch(input int mw);
      for (int i = 0; i < mw; i++)
         push(ov(4'd1, 7'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0), "fetch_wait");
      push(ov(4'd1, 7'b1010000, 2'd0, 2'd0, 1'b0, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0), "fetch_last");
   endtask

   function automatic logic [24:0] v_rst();
      return ov(4'd0, 7'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b1);
   endfunction
   function automatic logic [24:0] v_fi();
      return ov(4'd1, 7'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
   endfunction
   function automatic logic [24:0] v_exc();
      return ov(4'd12, 7'b1000001, 2'd3, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
   endfunction
   function automatic logic [24:0] v_exr(input logic [2:0] aop);
      return ov(4'd3, 7'b0000010, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, aop, 1'b0);
   endfunction
   function automatic logic [24:0] v_memaddr();
      return ov(4'd5, 7'b0000010, 2'd0, 2'd0, 1'b1, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0);
   endfunction
   function automatic logic [24:0] v_memrd();
      return ov(4'd6, 7'b0, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
   endfunction
   function automatic logic [24:0] v_exi();
      return ov(4'd4, 7'b0000010, 2'd0, 2'd0, 1'b1, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0);
   endfunction

   // Reset held for one cycle, released just after an edge, then the
   // instruction fetch and decode of the given instruction.
   task automatic start(input int sel, input int mw, input logic [5:0] op,
                        input logic [5:0] fn, input logic [5:0] fl);
      reset  = 1'b1;
      opcode = op;
      funct  = fn;
      flags  = fl;
      push(v_rst(), "rst_hold");
      drain(sel);
      reset = 1'b0;
      push(v_rst(), "rst_post");
      push_fetch(mw);
      push(ov(4'd2, 7'b0000110, 2'd0, 2'd0, 1'b0, 2'd3, 2'd0, 1'b0, 3'd0, 1'b0), "decode");
   endtask

   initial begin
      reset  = 1'b1;
      opcode = 6'h00;
      funct  = 6'h00;
      flags  = 6'h00;
      @(posedge clk);
      #1;

      // ADD, no overflow: write-back to rd on cycle 6, fetch again on 7
      start(0, 2, 6'h00, 6'h20, 6'h00);
      push(v_exr(3'd0), "add_exec");
      push(ov(4'd8, 7'b0001000, 2'd0, 2'd0, 1'b0, 2'd0, 2'd1, 1'b0, 3'd0, 1'b0), "add_wb");
      push(v_fi(), "add_next_fetch");
      drain(0);

      // SUB with overflow traps
      start(0, 2, 6'h00, 6'h22, 6'h01);
      push(v_exr(3'd1), "sub_exec");
      push(v_exc(), "sub_ovf_exc");
      push(v_fi(), "sub_next_fetch");
      drain(0);

      // AND ignores the overflow flag
      start(0, 2, 6'h00, 6'h24, 6'h01);
      push(v_exr(3'd2), "and_exec");
      push(ov(4'd8, 7'b0001000, 2'd0, 2'd0, 1'b0, 2'd0, 2'd1, 1'b0, 3'd0, 1'b0), "and_wb");
      push(v_fi(), "and_next_fetch");
      drain(0);

      // LW with MEM_WAIT=3
      start(1, 3, 6'h23, 6'h00, 6'h00);
      push(v_memaddr(), "lw_addr");
      for (int i = 0; i < 3; i++) push(v_memrd(), "lw_memrd");
      push(ov(4'd9, 7'b0001000, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0), "lw_wb");
      push(v_fi(), "lw_next_fetch");
      drain(1);

      // SW
      start(0, 2, 6'h2B, 6'h00, 6'h00);
      push(v_memaddr(), "sw_addr");
      push(ov(4'd7, 7'b0100000, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0), "sw_memwr");
      push(v_fi(), "sw_next_fetch");
      drain(0);

      // BEQ taken (zero set)
      start(0, 2, 6'h04, 6'h00, 6'h04);
      push(ov(4'd10, 7'b1000000, 2'd1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 3'd1, 1'b0), "beq_taken");
      push(v_fi(), "beq_next_fetch");
      drain(0);

      // BNE not taken (zero set)
      start(0, 2, 6'h05, 6'h00, 6'h04);
      push(ov(4'd10, 7'b0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 3'd1, 1'b0), "bne_not_taken");
      push(v_fi(), "bne_next_fetch");
      drain(0);

      // BNE taken (zero clear)
      start(0, 2, 6'h05, 6'h00, 6'h00);
      push(ov(4'd10, 7'b1000000, 2'd1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 3'd1, 1'b0), "bne_taken");
      push(v_fi(), "bne_t_next_fetch");
      drain(0);

      // ADDI overflow with trap enabled
      start(0, 2, 6'h08, 6'h00, 6'h01);
      push(v_exi(), "addi_exec");
      push(v_exc(), "addi_ovf_exc");
      push(v_fi(), "addi_next_fetch");
      drain(0);

      // ADDI overflow with trap disabled writes rt
      start(2, 2, 6'h08, 6'h00, 6'h01);
      push(v_exi(), "addi_nt_exec");
      push(ov(4'd8, 7'b0001000, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0), "addi_nt_wb");
      push(v_fi(), "addi_nt_next_fetch");
      drain(2);

      // Illegal opcode
      start(0, 2, 6'h11, 6'h00, 6'h00);
      push(v_exc(), "badop_exc");
      push(v_fi(), "badop_next_fetch");
      drain(0);

      // Illegal funct
      start(0, 2, 6'h00, 6'h2A, 6'h00);
      push(v_exr(3'd0), "badfn_exec");
      push(v_exc(), "badfn_exc");
      push(v_fi(), "badfn_next_fetch");
      drain(0);

      // Jump
      start(0, 2, 6'h02, 6'h00, 6'h00);
      push(ov(4'd11, 7'b1000000, 2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0), "jump");
      push(v_fi(), "jump_next_fetch");
      drain(0);

      // Software reset
      start(0, 2, 6'h3F, 6'h00, 6'h00);
      push(v_rst(), "swrst");
      push(v_fi(), "swrst_next_fetch");
      drain(0);

      // Asynchronous reset in the 2nd MEM_RD cycle
      start(0, 2, 6'h23, 6'h00, 6'h00);
      push(v_memaddr(), "lwr_addr");
      push(v_memrd(), "lwr_memrd1");
      drain(0);
      @(negedge clk);
      check(0, v_memrd(), "lwr_memrd2");
      #1 reset = 1'b1;
      #1 check(0, v_rst(), "async_rst_immediate");
      @(posedge clk);
      #1;
      push(v_rst(), "async_rst_hold");
      drain(0);
      reset = 1'b0;
      push(v_rst(), "async_rst_release");
      push(v_fi(), "async_rst_fetch");
      push(v_fi(), "async_rst_fetch_cnt1");
      drain(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
